// File: rtl/sw_debounce.sv
// Switch bus conditioner: 2-FF sync, tick-sampled debounce and a sticky,
// mask-clearable change-event register. Optional macro: SW_DEBOUNCE_BYPASS_EN.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous reset, active low
//   io_sw_raw_i   raw asynchronous switch pins
//   io_sw_o       debounced, registered switch level
//   sw_evt_o      sticky per-bit level-changed flags
//   sw_evt_pend_o OR of sw_evt_o, registered alongside it
//   evt_clr_i     one-cycle strobe clearing flags selected by evt_mask_i
//   evt_mask_i    flags to clear on evt_clr_i
module sw_debounce #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] io_sw_raw_i,
  output logic [WIDTH-1:0] io_sw_o,
  output logic [WIDTH-1:0] sw_evt_o,
  output logic             sw_evt_pend_o,
  input  logic             evt_clr_i,
  input  logic [WIDTH-1:0] evt_mask_i
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] io_sw_d, io_sw_q;
  logic [WIDTH-1:0] evt_d, evt_q;
  logic             pend_d, pend_q;
  logic [WIDTH-1:0] chg, clr_m;

`ifdef SW_DEBOUNCE_BYPASS_EN

  always_comb begin
    io_sw_d = sync2_q;
  end

`else

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]                  presc_d, presc_q;
  logic                           tick;
  logic [WIDTH-1:0][STABLE_CNT-1:0] hist_d, hist_q;

  // A level is accepted only when the whole history window,
  // including the sample just shifted in, agrees.
  always_comb begin
    tick    = (presc_q == PMAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    hist_d  = hist_q;
    io_sw_d = io_sw_q;
    if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_d[i] = {hist_q[i][STABLE_CNT-2:0], sync2_q[i]};
        if (&hist_d[i]) begin
          io_sw_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          io_sw_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      hist_q  <= '0;
    end else begin
      presc_q <= presc_d;
      hist_q  <= hist_d;
    end
  end

`endif

  // Set has priority over clear: chg is ORed in after masking.
  always_comb begin
    chg    = io_sw_d ^ io_sw_q;
    clr_m  = evt_clr_i ? evt_mask_i : '0;
    evt_d  = (evt_q & ~clr_m) | chg;
    pend_d = |evt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      io_sw_q <= '0;
      evt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      sync1_q <= io_sw_raw_i;
      sync2_q <= sync1_q;
      io_sw_q <= io_sw_d;
      evt_q   <= evt_d;
      pend_q  <= pend_d;
    end
  end

  assign io_sw_o       = io_sw_q;
  assign sw_evt_o      = evt_q;
  assign sw_evt_pend_o = pend_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (TICK_DIV=4, STABLE_CNT=3).
// Stimulus queues expected windows; a negedge monitor checks them.
module tb_sw_debounce;

  localparam int TD = 4;
  localparam int SC = 3;

  logic        clk;
  logic        rst_ni;
  logic [31:0] raw;
  logic [31:0] io_sw;
  logic [31:0] evt;
  logic        pend;
  logic        clr;
  logic [31:0] mask;

  sw_debounce #(
    .WIDTH(32),
    .TICK_DIV(TD),
    .STABLE_CNT(SC)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .io_sw_raw_i(raw),
    .io_sw_o(io_sw),
    .sw_evt_o(evt),
    .sw_evt_pend_o(pend),
    .evt_clr_i(clr),
    .evt_mask_i(mask)
  );

  typedef struct {
    string       name;
    bit          hold;
    int          lo;
    int          hi;
    logic [31:0] io;
    logic [31:0] evt;
    logic        pend;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   rel = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t m_e;
  bit   m_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic push(input string nm, input bit hold, input int lo,
                      input int hi, input logic [31:0] e_io,
                      input logic [31:0] e_evt, input logic e_pend);
    exp_t e;
    e.name = nm;
    e.hold = hold;
    e.lo   = lo;
    e.hi   = hi;
    e.io   = e_io;
    e.evt  = e_evt;
    e.pend = e_pend;
    q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int tick_at_or_after(input int n);
    int t;
    t = rel + TD;
    while (t < n) t = t + TD;
    return t;
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0 && cyc >= q[0].lo) begin
      m_e  = q[0];
      m_ok = (io_sw === m_e.io) && (evt === m_e.evt) &&
             (pend === m_e.pend);
      if (m_e.hold ? (!m_ok || cyc >= m_e.hi) : (m_ok || cyc >= m_e.hi)) begin
        checks = checks + 1;
        if (!m_ok) begin
          errors = errors + 1;
          $display("FAIL %s cyc=%0d got io=%h evt=%h pend=%b want io=%h evt=%h pend=%b",
                   m_e.name, cyc, io_sw, evt, pend, m_e.io, m_e.evt, m_e.pend);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int t;
    rst_ni = 1'b0;
    raw    = '0;
    clr    = 1'b0;
    mask   = '0;
    push("reset", 1, 1, 2, 32'h0, 32'h0, 1'b0);
    goto(3);
    rst_ni = 1'b1;
    rel    = cyc;
    push("idle", 1, 3, 23, 32'h0, 32'h0, 1'b0);
    goto(24);
    checks = checks + 1;
    if (io_sw !== 32'h0 || evt !== 32'h0 || pend !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL idle_now cyc=%0d io=%h evt=%h pend=%b",
               cyc, io_sw, evt, pend);
    end
`ifdef SW_DEBOUNCE_BYPASS_EN
    n   = cyc;
    raw = 32'h8;
    push("pre_byp", 1, n, n + 2, 32'h0, 32'h0, 1'b0);
    push("byp_rise", 1, n + 3, n + 3, 32'h8, 32'h8, 1'b1);
    goto(n + 6);
    n   = cyc;
    raw = 32'h0;
    push("pre_byp_fall", 1, n, n + 2, 32'h8, 32'h8, 1'b1);
    push("byp_fall", 1, n + 3, n + 3, 32'h0, 32'h8, 1'b1);
    goto(n + 6);
`else
    n   = cyc;
    raw = 32'h1;
    push("pre_rise0", 1, n, n + 10, 32'h0, 32'h0, 1'b0);
    push("rise0", 0, n + 11, n + 15, 32'h1, 32'h1, 1'b1);
    goto(n + 16);
    n   = cyc;
    raw = 32'h21;
    push("glitch5", 1, n, n + 40, 32'h1, 32'h1, 1'b1);
    goto(n + 5);
    raw = 32'h1;
    goto(n + 41);
    n   = cyc;
    raw = 32'hFF00_00FF;
    push("pre4", 1, n, n + 10, 32'h1, 32'h1, 1'b1);
    push("rise4", 0, n + 11, n + 15, 32'hFF00_00FF, 32'hFF00_00FF, 1'b1);
    goto(n + 16);
    n    = cyc;
    clr  = 1'b1;
    mask = 32'h0000_00FF;
    push("clr_lo", 1, n + 1, n + 5, 32'hFF00_00FF, 32'hFF00_0000, 1'b1);
    goto(n + 1);
    clr  = 1'b0;
    mask = '0;
    goto(n + 6);
    n   = cyc;
    raw = 32'hFF00_00FE;
    t   = tick_at_or_after(n + 3) + (SC - 1) * TD;
    push("pre5", 1, n, t - 1, 32'hFF00_00FF, 32'hFF00_0000, 1'b1);
    push("set_wins", 1, t, t, 32'hFF00_00FE, 32'hFF00_0001, 1'b1);
    goto(t - 1);
    clr  = 1'b1;
    mask = 32'h1;
    goto(t);
    clr  = 1'b0;
    mask = '0;
    goto(t + 1);
    clr = 1'b1;
    push("mask0", 1, t + 2, t + 5, 32'hFF00_00FE, 32'hFF00_0001, 1'b1);
    goto(t + 2);
    clr = 1'b0;
    goto(t + 6);
    clr  = 1'b1;
    mask = '1;
    push("clr_all", 1, t + 7, t + 7, 32'hFF00_00FE, 32'h0, 1'b0);
    goto(t + 7);
    clr  = 1'b0;
    mask = '0;
    n    = cyc;
    raw  = 32'h0;
    push("fall_all", 0, n + 11, n + 15, 32'h0, 32'hFF00_00FE, 1'b1);
    goto(n + 17);
    n   = cyc;
    raw = 32'h8;
    t   = tick_at_or_after(n + 3) + TD;
    push("pre_rst", 1, n, t - 1, 32'h0, 32'hFF00_00FE, 1'b1);
    goto(t);
    rst_ni = 1'b0;
    #1;
    checks = checks + 1;
    if (io_sw !== 32'h0 || evt !== 32'h0 || pend !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rst_now cyc=%0d io=%h evt=%h pend=%b",
               cyc, io_sw, evt, pend);
    end
    push("rst_hold", 1, t, t + 13, 32'h0, 32'h0, 1'b0);
    push("rerise3", 1, t + 14, t + 14, 32'h8, 32'h8, 1'b1);
    goto(t + 2);
    rst_ni = 1'b1;
    rel    = cyc;
    goto(t + 17);
`endif
    for (int i = 0; i < 50 && q.size() != 0; i++) goto(cyc + 1);
    while (q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s never checked, pending at cyc=%0d", q[0].name, cyc);
      void'(q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
